bcd_count_ctrl: RTL
===================

# bcd_count_ctrl

Run-control sequencer for a chain of cascaded decade (BCD) digit counters. It owns the count-enable prescaler, the digit-to-digit carry enables and a start/pause/clear/terminal-count state machine. It turns the free-running decade-counter datapath into a programmable BCD interval timer. The block sits between the front-panel command logic and the digit display/compare logic.

## Interface
- DIGITS, 3: number of cascaded BCD digits; count range 0 to 10^DIGITS-1.
- PRESCALE, 4: clk cycles per count tick; must be 1 or greater.

Ports (clock and reset first):
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  level-sampled command: begin from IDLE/DONE, or resume from PAUSE.
- pause  in  1  level-sampled command: freeze count while in RUN.
- clear  in  1  level-sampled command: abort to IDLE and zero the count.
- target  in  4*DIGITS  BCD terminal count; digit i is target[4i+3:4i].
- cnt  out  4*DIGITS  current BCD count, registered.
- dig_en  out  DIGITS  per-digit increment enable, combinational, high in the cycle an increment is committed.
- state  out  2  FSM state: 0=IDLE, 1=RUN, 2=PAUSE, 3=DONE.
- busy  out  1  high when state is RUN or PAUSE.
- done  out  1  one-cycle pulse when terminal count is reached.

## Operation
- Command priority, in every state: clear > pause > start.
- clear (any state): next state IDLE, cnt=0, prescaler=0.
- IDLE, start:
  - Latch target into target_q. Any nibble greater than 9 is saturated to 9.
  - cnt=0, prescaler=0, next state RUN.
- RUN:
  - The prescaler counts 0..PRESCALE-1. tick = (prescaler==PRESCALE-1) and no pause and no clear.
  - On tick, the prescaler wraps to 0 and cnt takes its BCD increment.
  - pause: next state PAUSE. Prescaler and cnt hold, and no tick occurs in that cycle.
- Carry chain:
  - dig_en[0] = tick.
  - dig_en[i] = tick and all digits below i equal 9.
  - Any digit with dig_en set goes 9 to 0 if it equals 9, otherwise it increments by 1.
- Terminal count:
  - When the post-increment cnt equals target_q, next state is DONE and done=1 for exactly one cycle.
  - target_q=0 means full range: the count wraps from all-9s to 0, and done fires on that wrap after 10^DIGITS ticks.
- PAUSE:
  - start resumes RUN with the prescaler phase preserved.
  - pause and start asserted together: stay in PAUSE.
- DONE:
  - cnt holds target_q.
  - start re-latches target and restarts from 0, exactly as from IDLE.
- The sampled target is ignored outside the IDLE/DONE start cycle.
- Width rules:
  - The prescaler is max(1, clog2(PRESCALE)) bits.
  - With PRESCALE=1, every RUN cycle without pause or clear is a tick.

## Timing
- Reset values: state=IDLE, cnt=0, dig_en=0, busy=0, done=0. Internal prescaler=0 and target_q=0.
- rst asserted mid-operation takes effect at the next edge, overriding all commands.
- Start latency:
  - start sampled at edge N gives state=RUN and busy=1 after edge N.
  - The first tick is committed in the cycle ending at edge N+PRESCALE.
  - The first increment is visible after edge N+PRESCALE.
- Increments are spaced exactly PRESCALE cycles apart while in RUN.
- done, state=DONE and the final cnt value all update on the same edge; done clears on the following edge.
- dig_en is valid only in the cycle before the edge that updates cnt.

## Test plan
- Reset: hold rst for 2 cycles with start=1 -> state=0, cnt=0x000, busy=0, done=0, dig_en=0 throughout and after.
- Normal run:
  - Stimulus: target=0x012, one-cycle start.
  - cnt steps 000,001,…,012, one step every 4 cycles.
  - dig_en=3'b011 on the 009->010 tick.
  - done pulses once on the 12th increment (48 cycles after RUN entry); state=3, busy=0.
- Pause/resume:
  - Stimulus: pause at cnt=0x005 with the prescaler at 2, hold for 10 cycles, then start.
  - cnt stays at 005 while paused.
  - The next increment lands 2 cycles after resume (prescaler phase preserved).
- Full-range wrap:
  - Stimulus: target=0x000, start.
  - After 999 ticks cnt=0x999.
  - The next tick has dig_en=3'b111, cnt becomes 0x000 and done pulses.
- Priority: clear, pause and start all high in RUN at cnt=0x007 -> next edge state=IDLE, cnt=0x000, no done.
- Saturation and mid-run reset:
  - Stimulus: target=0x0A3, start.
  - Run terminates at cnt=0x093.
  - Restart, then assert rst at cnt=0x040 -> next edge state=IDLE, cnt=0x000.

Source files
------------

// File: rtl/bcd_count_ctrl.sv
// Run-control sequencer for a cascade of BCD digit counters:
// prescaler, digit carry enables and start/pause/clear/done FSM.
module bcd_count_ctrl #(
    parameter int DIGITS   = 3,
    parameter int PRESCALE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  clear,
    input  logic [4*DIGITS-1:0]   target,
    output logic [4*DIGITS-1:0]   cnt,
    output logic [DIGITS-1:0]     dig_en,
    output logic [1:0]            state,
    output logic                  busy,
    output logic                  done
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [4*DIGITS-1:0] cnt_q, cnt_d;
    logic [4*DIGITS-1:0] tgt_q, tgt_d;
    logic [PW-1:0]       pre_q, pre_d;
    logic                done_q, done_d;

    logic                tick;
    logic [4*DIGITS-1:0] cnt_inc;
    logic [4*DIGITS-1:0] tgt_sat;

    // Nibbles above 9 are not valid BCD; clamp them so the run can terminate.
    always_comb begin
        tgt_sat = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (target[4*i +: 4] > 4'd9) tgt_sat[4*i +: 4] = 4'd9;
            else                         tgt_sat[4*i +: 4] = target[4*i +: 4];
        end
    end

    assign tick = (state_q == S_RUN) && (pre_q == PRE_MAX) && !pause && !clear;

    always_comb begin
        logic all9;
        dig_en  = '0;
        cnt_inc = cnt_q;
        all9    = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            dig_en[i] = tick && all9;
            if (dig_en[i]) begin
                if (cnt_q[4*i +: 4] == 4'd9) cnt_inc[4*i +: 4] = 4'd0;
                else cnt_inc[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
            end
            all9 = all9 && (cnt_q[4*i +: 4] == 4'd9);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        pre_d   = pre_q;
        done_d  = 1'b0;
        if (clear) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            pre_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (!pause && start) begin
                        tgt_d   = tgt_sat;
                        cnt_d   = '0;
                        pre_d   = '0;
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (pause) begin
                        state_d = S_PAUSE;
                    end else if (tick) begin
                        pre_d = '0;
                        cnt_d = cnt_inc;
                        // A zero target only matches on the all-9s wrap.
                        if (cnt_inc == tgt_q) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (!pause && start) state_d = S_RUN;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tgt_q   <= '0;
            pre_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            pre_q   <= pre_d;
            done_q  <= done_d;
        end
    end

    assign cnt   = cnt_q;
    assign state = state_q;
    assign busy  = (state_q == S_RUN) || (state_q == S_PAUSE);
    assign done  = done_q;

endmodule
